match_sequencer: RTL and testbench

MATCH_SEQUENCER -- requirements
Module: match_sequencer

---
 rtl/match_sequencer.sv | 163 ++++++++++++++++
 tb/tb_match_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/match_sequencer.sv
// match_sequencer: scans NPLACE template placements over a signal memory,
// streams WIN_LEN operand pairs per placement into an external scoring
// datapath, and keeps the placement with the lowest score (earliest wins ties).
module match_sequencer #(
    parameter int WIN_LEN = 16,
    parameter int NPLACE  = 40,
    parameter int RES_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [5:0]  f_addr,
    output logic [6:0]  g_addr,
    input  logic [2:0]  f_rdata,
    input  logic [2:0]  g_rdata,
    output logic        lstart,
    output logic        startsig,
    output logic        work,
    output logic        valid,
    output logic        finalstart,
    output logic        change,
    output logic [5:0]  startplace,
    output logic [2:0]  fdata,
    output logic [2:0]  gdata,
    input  logic [17:0] result,
    output logic        busy,
    output logic        done,
    output logic [5:0]  best_place,
    output logic [17:0] best_result
);

    localparam logic [5:0]  SIDX_LAST = 6'(WIN_LEN - 1);
    localparam logic [5:0]  PIDX_LAST = 6'(NPLACE - 1);
    localparam logic [15:0] WAIT_LAST = 16'(RES_LAT - 1);
    localparam logic [17:0] WORST     = 18'h3FFFF;

    typedef enum logic [2:0] {
        IDLE, LOAD, STREAM, DRAIN, FINAL, WAIT, CMP, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  pidx_q, pidx_d;
    logic [5:0]  sidx_q, sidx_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        valid_q;
    logic [5:0]  best_place_q, best_place_d;
    logic [17:0] best_result_q, best_result_d;

    // State and scan counters; reset abandons any run in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pidx_q        <= '0;
            sidx_q        <= '0;
            wcnt_q        <= '0;
            valid_q       <= 1'b0;
            best_place_q  <= '0;
            best_result_q <= WORST;
        end else begin
            state_q       <= state_d;
            pidx_q        <= pidx_d;
            sidx_q        <= sidx_d;
            wcnt_q        <= wcnt_d;
            // read data returns one cycle after each address issue
            valid_q       <= (state_q == STREAM);
            best_place_q  <= best_place_d;
            best_result_q <= best_result_d;
        end
    end

    // Next-state sequencing, best-score tracking and control decode
    always_comb begin
        state_d       = state_q;
        pidx_d        = pidx_q;
        sidx_d        = sidx_q;
        wcnt_d        = wcnt_q;
        best_place_d  = best_place_q;
        best_result_d = best_result_q;
        lstart        = 1'b0;
        startsig      = 1'b0;
        work          = 1'b0;
        finalstart    = 1'b0;
        change        = 1'b0;
        done          = 1'b0;
        f_addr        = '0;
        g_addr        = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = LOAD;
                    pidx_d        = '0;
                    sidx_d        = '0;
                    best_place_d  = '0;
                    best_result_d = WORST;
                end
            end
            LOAD: begin
                lstart   = 1'b1;
                startsig = 1'b1;
                state_d  = STREAM;
                sidx_d   = '0;
            end
            STREAM: begin
                work   = 1'b1;
                f_addr = sidx_q;
                g_addr = {1'b0, pidx_q} + {1'b0, sidx_q};
                if (sidx_q == SIDX_LAST) begin
                    state_d = DRAIN;
                    sidx_d  = '0;
                end else begin
                    sidx_d = sidx_q + 6'd1;
                end
            end
            DRAIN: begin
                // last read data of the window is still in flight here
                work    = 1'b1;
                state_d = FINAL;
            end
            FINAL: begin
                finalstart = 1'b1;
                state_d    = WAIT;
                wcnt_d     = '0;
            end
            WAIT: begin
                if (wcnt_q == WAIT_LAST) begin
                    state_d = CMP;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
            end
            CMP: begin
                // strict compare so ties keep the earlier placement
                if (result < best_result_q) begin
                    best_result_d = result;
                    best_place_d  = pidx_q;
                end
                if (pidx_q == PIDX_LAST) begin
                    state_d = DONE;
                end else begin
                    change  = 1'b1;
                    pidx_d  = pidx_q + 6'd1;
                    sidx_d  = '0;
                    state_d = STREAM;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign valid       = valid_q;
    assign fdata       = valid_q ? f_rdata : 3'd0;
    assign gdata       = valid_q ? g_rdata : 3'd0;
    assign startplace  = pidx_q;
    assign best_place  = best_place_q;
    assign best_result = best_result_q;

endmodule

// File: tb/tb_match_sequencer.sv
// tb_match_sequencer: drives randomized runs of match_sequencer with a memory
// model and a per-placement score table, and checks every cycle against a
// timeline computed arithmetically from the run structure.
module tb_match_sequencer;

    localparam int W      = 4;
    localparam int N      = 3;
    localparam int R      = 3;
    localparam int L      = W + R + 3;
    localparam int DONE_C = 2 + N * L;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [5:0]  f_addr, startplace, best_place;
    logic [6:0]  g_addr;
    logic [2:0]  f_rdata, g_rdata, fdata, gdata;
    logic        lstart, startsig, work, valid, finalstart, change, busy, done;
    logic [17:0] result, best_result;

    logic [2:0]  f_mem [64];
    logic [2:0]  g_mem [128];
    logic [17:0] res   [64];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          prev_bp;
    logic [17:0] prev_br;

    match_sequencer #(.WIN_LEN(W), .NPLACE(N), .RES_LAT(R)) dut (
        .clk(clk), .rst(rst), .start(start),
        .f_addr(f_addr), .g_addr(g_addr), .f_rdata(f_rdata), .g_rdata(g_rdata),
        .lstart(lstart), .startsig(startsig), .work(work), .valid(valid),
        .finalstart(finalstart), .change(change), .startplace(startplace),
        .fdata(fdata), .gdata(gdata), .result(result), .busy(busy), .done(done),
        .best_place(best_place), .best_result(best_result)
    );

    always #5 clk = ~clk;

    // one-cycle-latency memories and a score lookup for the current placement
    always @(posedge clk) begin
        f_rdata <= f_mem[f_addr];
        g_rdata <= g_mem[g_addr];
    end
    assign result = res[startplace];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 64; i++)  f_mem[i] = 3'($urandom_range(0, 7));
        for (int i = 0; i < 128; i++) g_mem[i] = 3'($urandom_range(0, 7));
    endtask

    // One run: start accepted at cycle 0, done expected at cycle DONE_C.
    // inj_c: cycle at which an extra start is pulsed (0 = none).
    // rst_c: cycle at which reset is asserted mid-run (0 = none).
    task automatic run_scan(input string name, input int inj_c, input int rst_c);
        int          exp_bp;
        logic [17:0] exp_br;
        int          n_l, n_ch, n_fs;
        int          p, o;
        logic [7:0]  exp_ctrl;
        logic [7:0]  got_ctrl;
        int          exp_sp;
        logic [2:0]  exp_fd, exp_gd;
        n_l = 0; n_ch = 0; n_fs = 0;
        exp_bp = 0;
        exp_br = res[0];
        for (int i = 1; i < N; i++) begin
            if (res[i] < exp_br) begin
                exp_br = res[i];
                exp_bp = i;
            end
        end

        @(negedge clk);
        check({name, " idle_busy"}, 32'(busy), 32'd0);
        check({name, " held_place"}, 32'(best_place), 32'(prev_bp));
        check({name, " held_result"}, 32'(best_result), 32'(prev_br));
        start = 1'b1;

        for (int c = 1; c <= DONE_C; c++) begin
            @(negedge clk);
            start = (c == inj_c);
            exp_ctrl = '0;
            exp_sp   = 0;
            exp_fd   = 3'd0;
            exp_gd   = 3'd0;
            p = 0;
            o = 0;
            if (c == 1) begin
                exp_ctrl = 8'b1011_0000;
            end else if (c == DONE_C) begin
                exp_ctrl = 8'b1100_0000;
                exp_sp   = N - 1;
            end else begin
                p = (c - 2) / L;
                o = (c - 2) % L;
                exp_sp = p;
                exp_ctrl[7] = 1'b1;
                exp_ctrl[3] = (o <= W);
                exp_ctrl[2] = (o >= 1 && o <= W);
                exp_ctrl[1] = (o == W + 1);
                exp_ctrl[0] = (o == L - 1) && (p < N - 1);
                if (o >= 1 && o <= W) begin
                    exp_fd = f_mem[o - 1];
                    exp_gd = g_mem[p + o - 1];
                end
            end
            got_ctrl = {busy, done, lstart, startsig, work, valid, finalstart, change};
            check({name, " ctrl"}, 32'(got_ctrl), 32'(exp_ctrl));
            check({name, " startplace"}, 32'(startplace), 32'(exp_sp));
            check({name, " fdata"}, 32'(fdata), 32'(exp_fd));
            check({name, " gdata"}, 32'(gdata), 32'(exp_gd));
            if (c >= 2 && c < DONE_C && o < W) begin
                check({name, " f_addr"}, 32'(f_addr), 32'(o));
                check({name, " g_addr"}, 32'(g_addr), 32'(p + o));
            end
            n_l  += int'(lstart);
            n_ch += int'(change);
            n_fs += int'(finalstart);

            if (c == rst_c) begin
                rst = 1'b1;
                #1;
                check({name, " rst_busy"}, 32'(busy), 32'd0);
                check({name, " rst_ctrl"}, 32'({busy, done, lstart, startsig, work, valid, finalstart, change}), 32'd0);
                check({name, " rst_result"}, 32'(best_result), 32'h3FFFF);
                check({name, " rst_place"}, 32'(best_place), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                for (int k = 0; k < DONE_C; k++) begin
                    @(negedge clk);
                    check({name, " post_rst_done"}, 32'({busy, done}), 32'd0);
                end
                prev_bp = 0;
                prev_br = 18'h3FFFF;
                $display("run %s: aborted by reset at cycle %0d", name, c);
                return;
            end
        end

        check({name, " best_place"}, 32'(best_place), 32'(exp_bp));
        check({name, " best_result"}, 32'(best_result), 32'(exp_br));
        check({name, " n_lstart"}, 32'(n_l), 32'd1);
        check({name, " n_change"}, 32'(n_ch), 32'(N - 1));
        check({name, " n_finalstart"}, 32'(n_fs), 32'(N));
        prev_bp = exp_bp;
        prev_br = exp_br;
        $display("run %s: results %0d,%0d,%0d -> best place %0d score %0d",
                 name, res[0], res[1], res[2], best_place, best_result);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 64; i++) res[i] = 18'd0;
        fill_mem();
        @(negedge clk);
        check("reset_ctrl", 32'({busy, done, lstart, startsig, work, valid, finalstart, change}), 32'd0);
        check("reset_addr", 32'({f_addr, g_addr, startplace}), 32'd0);
        check("reset_data", 32'({fdata, gdata}), 32'd0);
        check("reset_best_place", 32'(best_place), 32'd0);
        check("reset_best_result", 32'(best_result), 32'h3FFFF);
        rst     = 1'b0;
        prev_bp = 0;
        prev_br = 18'h3FFFF;

        // single minimum
        res[0] = 18'd500; res[1] = 18'd200; res[2] = 18'd300;
        run_scan("min", 0, 0);

        // tie keeps earliest; extra start during STREAM of placement 1
        fill_mem();
        res[0] = 18'd100; res[1] = 18'd100; res[2] = 18'd150;
        run_scan("tie", 2 + L + 1, 0);

        // start coinciding with DONE is ignored, next IDLE start accepted
        fill_mem();
        for (int i = 0; i < N; i++) res[i] = 18'($urandom_range(0, 1000));
        run_scan("done_start", DONE_C, 0);

        // reset during WAIT of placement 1
        fill_mem();
        for (int i = 0; i < N; i++) res[i] = 18'($urandom_range(0, 1000));
        run_scan("rst_wait", 0, 2 + L + W + 2);

        // randomized runs, some with small score ranges to provoke ties
        for (int r = 0; r < 8; r++) begin
            fill_mem();
            for (int i = 0; i < N; i++)
                res[i] = (r % 2 == 0) ? 18'($urandom_range(0, 3)) : 18'($urandom_range(0, 18'h3FFFE));
            run_scan($sformatf("rand%0d", r),
                     (r % 3 == 0) ? 0 : 2 + $urandom_range(0, N - 1) * L + $urandom_range(0, W - 1), 0);
        end

        @(negedge clk);
        start = 1'b0;
        check("final_held_place", 32'(best_place), 32'(prev_bp));
        check("final_held_result", 32'(best_result), 32'(prev_br));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
